// File: rtl/mod_inv.sv
// Modular inverse mod Q by Fermat square-and-multiply on a 3-stage Barrett multiplier.
// Optional operand range check enabled by defining MOD_INV_RANGE_CHECK_EN.
module mod_inv #(
  parameter int unsigned Q   = 3329,
  parameter int unsigned EXP = 3327
) (
  input  logic        clk,
  input  logic        r,
  input  logic [11:0] A,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] OUT,
  output logic        err,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [11:0] EXP_B = EXP[11:0];
  localparam logic [12:0] MU    = 13'((32'd1 << 24) / Q);
  localparam logic [12:0] Q13   = 13'(Q);
  localparam logic [13:0] Q14   = 14'(Q);
  localparam logic [13:0] Q2_14 = 14'(2 * Q);

  typedef enum logic [1:0] {
    IDLE,
    SQR,
    MUL,
    DONE
  } state_t;

  state_t      state;
  logic [11:0] acc;
  logic [11:0] base;
  logic [3:0]  idx;
  logic        issued;

  logic        issue;
  logic [11:0] op_b;
  logic [23:0] p1;
  logic [13:0] p2;
  logic [12:0] q2;
  logic [11:0] m3;
  logic        v1, v2, v3;
  logic [12:0] qest;
  logic [13:0] r14;
  logic [11:0] red;

  // Squares use acc twice; multiplies pair acc with the saved base.
  assign op_b  = (state == MUL) ? base : acc;
  assign issue = ((state == SQR) || (state == MUL)) && !issued;

  // Barrett quotient estimate; true remainder is below 3Q so 14 bits suffice.
  assign qest = 13'((37'(p1) * 37'(MU)) >> 24);
  assign r14  = p2 - 14'(q2 * Q13);

  // Final conditional subtraction brings the remainder into 0..Q-1.
  always_comb begin
    red = r14[11:0];
    if (r14 >= Q2_14) begin
      red = 12'(r14 - Q2_14);
    end else if (r14 >= Q14) begin
      red = 12'(r14 - Q14);
    end
  end

  // Multiplier pipeline: product, quotient estimate, reduced result.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      p1 <= '0;
      p2 <= '0;
      q2 <= '0;
      m3 <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= issue;
      v2 <= v1;
      v3 <= v2;
      if (issue) begin
        p1 <= acc * op_b;
      end
      q2 <= qest;
      p2 <= p1[13:0];
      m3 <= red;
    end
  end

`ifdef MOD_INV_RANGE_CHECK_EN
  logic bad_op;
  assign bad_op = (A == 12'd0) || (A >= 12'(Q));
`endif

  // Control FSM: scans exponent bits MSB-first, one multiplier op at a time.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      OUT       <= '0;
      acc       <= '0;
      base      <= '0;
      idx       <= '0;
      issued    <= 1'b0;
`ifdef MOD_INV_RANGE_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            base     <= A;
            acc      <= A;
            idx      <= 4'd10;
            issued   <= 1'b0;
`ifdef MOD_INV_RANGE_CHECK_EN
            err      <= bad_op;
            if (bad_op) begin
              state     <= DONE;
              out_valid <= 1'b1;
              OUT       <= '0;
            end else begin
              state <= SQR;
            end
`else
            state <= SQR;
`endif
          end
        end
        SQR: begin
          if (issue) begin
            issued <= 1'b1;
          end else if (v3) begin
            acc    <= m3;
            issued <= 1'b0;
            if (EXP_B[idx]) begin
              state <= MUL;
            end else if (idx == 4'd0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              OUT       <= m3;
            end else begin
              idx <= idx - 4'd1;
            end
          end
        end
        MUL: begin
          if (issue) begin
            issued <= 1'b1;
          end else if (v3) begin
            acc    <= m3;
            issued <= 1'b0;
            if (idx == 4'd0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              OUT       <= m3;
            end else begin
              idx   <= idx - 4'd1;
              state <= SQR;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MOD_INV_RANGE_CHECK_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_inv.sv
// Scoreboard bench for mod_inv: random and directed operands vs a brute-force inverse.
// Checks value, err, latency, backpressure hold and reset abort.
module tb_mod_inv;

  localparam int Q = 3329;

  logic        clk;
  logic        r;
  logic [11:0] A;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] OUT;
  logic        err;
  logic        out_valid;
  logic        out_ready;

  mod_inv dut (
    .clk      (clk),
    .r        (r),
    .A        (A),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .OUT      (OUT),
    .err      (err),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  typedef struct {
    int out;
    int err;
    int lat;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   ncmp;
  int   nfail;
  int   cyc;
  bit   seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int expv);
    ncmp++;
    if (act != expv) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Inverse by exhaustive search: x such that a*x = 1 mod Q.
  function automatic int ref_inv(int a);
    if (a % Q == 0) return 0;
    for (int x = 1; x < Q; x++) begin
      if ((a * x) % Q == 1) return x;
    end
    return 0;
  endfunction

  // Monitor: compare whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    if (r && out_valid) begin
      if (sb.size() == 0) begin
        nfail++;
        ncmp++;
        $display("FAIL unexpected_out_valid: got OUT=%0d expected no output", OUT);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("latency", cyc - sb[0].acc, sb[0].lat);
        end
        chk("out", int'(OUT), sb[0].out);
        chk("err", int'(err), sb[0].err);
        chk("in_ready_busy", int'(in_ready), 0);
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(int a, bit hold);
    exp_t e;
    int   n;
    e.out = ref_inv(a);
    e.err = 0;
    e.lat = 80;
`ifdef MOD_INV_RANGE_CHECK_EN
    if (a == 0 || a >= Q) begin
      e.out = 0;
      e.err = 1;
      e.lat = 1;
    end
`endif
    @(negedge clk);
    in_valid = 1'b1;
    A = 12'(a);
    n = 0;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      chk("accept_timeout", n, 0);
    end
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    if (!hold) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ncmp = 0;
    nfail = 0;
    cyc = 0;
    seen = 1'b0;
    r = 1'b0;
    A = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out", int'(OUT), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    r = 1'b1;

    send(1, 0);
    drain();
    send(2, 0);
    drain();
    send(17, 0);
    drain();
    send(3328, 0);
    drain();

    send(2, 1);
    send(17, 0);
    drain();

    out_ready = 1'b0;
    send(2, 0);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", int'(out_valid), 1);
    repeat (10) @(negedge clk);
    out_ready = 1'b1;
    drain();

    send(17, 0);
    repeat (40) @(posedge clk);
    #2;
    r = 1'b0;
    sb.delete();
    seen = 1'b0;
    #2;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_out", int'(OUT), 0);
    chk("abort_err", int'(err), 0);
    @(negedge clk);
    r = 1'b1;
    repeat (100) @(negedge clk);
    send(2, 0);
    drain();

    send(0, 0);
    drain();
`ifdef MOD_INV_RANGE_CHECK_EN
    send(3329, 0);
    drain();
    send(4095, 0);
    drain();
`endif

    repeat (10) begin
      out_ready = 1'($urandom_range(0, 1));
      send(int'($urandom_range(1, Q - 1)), 0);
      if (!out_ready) begin
        n = 0;
        while (!out_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        repeat ($urandom_range(1, 5)) @(negedge clk);
        out_ready = 1'b1;
      end
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mod_inv.md
MOD_INV -- requirements
Module: mod_inv

Interface
REQ-001 Parameter: Q, default 3329, Kyber prime modulus.
REQ-002 Parameter: EXP, default 3327 (Q-2), Fermat exponent, MSB-first scan over 12 bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 r  input  1  reset, asynchronous, active-low.
REQ-005 A  input  12  operand to invert, unsigned.
REQ-006 in_valid  input  1  A is valid this cycle.
REQ-007 in_ready  output  1  block can accept an operand.
REQ-008 OUT  output  12  A^-1 mod Q, in range 0..Q-1.
REQ-009 err  output  1  operand not invertible/out of range; qualified by out_valid.
REQ-010 out_valid  output  1  OUT/err valid.
REQ-011 out_ready  input  1  consumer accepts OUT.

Function
REQ-012 The block SHALL compute OUT = A^(Q-2) mod Q by left-to-right square-and-multiply, so that A*OUT mod Q = 1 for 1 <= A <= Q-1.
REQ-013 The block SHALL hold one internal 3-stage pipelined Barrett modular multiplier (12x12 product, reduce mod Q, latency 3); square and multiply steps share it.
REQ-014 FSM states: IDLE, SQR, MUL, DONE.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready, latch A into base and acc (EXP MSB consumed), bit index=10, go to SQR.
REQ-016 SQR: issue acc*acc in cycle 1, capture result in cycle 4 (4 cycles/op); then go to MUL if EXP[index]=1, else decrement index.
REQ-017 MUL: issue acc*base, capture after 4 cycles, then decrement index.
REQ-018 After the op at index 0 completes, go to DONE; for EXP=3327, 11 squares + 9 multiplies = 20 ops.
REQ-019 out_valid SHALL rise exactly 80 cycles after the accepting edge for a valid non-zero A.
REQ-020 DONE: out_valid=1, OUT and err stable until out_valid&&out_ready; then IDLE with in_ready=1 on the following cycle.
REQ-021 in_ready=0 in SQR, MUL, DONE; in_valid is ignored there (no queueing, no overwrite).
REQ-022 Intermediate values SHALL stay fully reduced (0..Q-1); widths 12 bits for acc/base, 24 bits for the product.
REQ-023 out_ready held high in DONE: handshake completes in the first DONE cycle (out_valid high exactly one cycle).

Reset
REQ-024 r low SHALL asynchronously force: state=IDLE, in_ready=1, out_valid=0, OUT=0, err=0, acc=0, base=0, index=0, multiplier pipeline registers and valid bits=0.
REQ-025 Reset asserted mid-computation SHALL abort the operation; no out_valid is produced for it.
REQ-026 After r deasserts, the first operand SHALL be accepted on the first rising edge with in_valid=1.

Configuration
REQ-027 Macro MOD_INV_RANGE_CHECK_EN defined: A=0 or A>=Q bypasses the exponentiation; DONE is entered on the accepting edge, and out_valid is high on the next cycle with OUT=0, err=1.
REQ-028 Macro undefined: no range check; err is tied to 0; A=0 runs the full 80 cycles and returns OUT=0; A>=Q is treated as its residue through the multiplier, with the result unspecified for A>=Q.

Verification
REQ-029 Reset then A=1 -> out_valid 80 cycles after accept, OUT=1, err=0.
REQ-030 A=2 -> OUT=1665; A=17 -> OUT=1175; A=3328 -> OUT=3328, each with 80-cycle latency.
REQ-031 Back-to-back: in_valid held high with A=2 then A=17, out_ready=1 -> second accepted only after first out_valid handshake; outputs 1665 then 1175.
REQ-032 Backpressure: out_ready=0 for 10 cycles in DONE -> OUT=1665 and out_valid held stable; in_ready stays 0.
REQ-033 r pulsed low at cycle 40 of A=17 -> out_valid never rises for it; next A=2 yields 1665.
REQ-034 With MOD_INV_RANGE_CHECK_EN: A=0 and A=3329 -> out_valid next cycle, OUT=0, err=1; without it: A=0 -> OUT=0 after 80 cycles, err=0.
